// File: rtl/pdm_mic_capture_pkg.sv
// pdm_mic_pkg: shared definitions for the PDM microphone capture block.
//   - default parameter values for the top level
//   - channel encodings (left = 0, right = 1)
//   - width helpers for the ones/bit counters and the FIFO level
//   - FIFO entry layout {ch, data} at the default sample width
`timescale 1ns/1ps
package pdm_mic_pkg;

  localparam int DEF_CLK_DIV    = 4;
  localparam int DEF_DECIM      = 64;
  localparam int DEF_SAMPLE_W   = 16;
  localparam int DEF_NUM_CH     = 1;
  localparam int DEF_FIFO_DEPTH = 8;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

  // Counter width able to hold 0..decim inclusive.
  function automatic int cnt_w(input int decim);
    return $clog2(decim + 1);
  endfunction

  // Level width able to hold 0..depth inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CNT_W = cnt_w(DEF_DECIM);
  localparam int LVL_W = lvl_w(DEF_FIFO_DEPTH);

  typedef struct packed {
    logic                    ch;
    logic [DEF_SAMPLE_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/pdm_mic_capture_if.sv
// pdm_mic_capture_if: sample output stream of the PDM capture block.
//   sample_data/sample_ch/sample_valid : head-of-FIFO sample (master drives)
//   sample_ready                       : consumer accepts head (slave drives)
//   fifo_level/overflow                : status (master drives)
`timescale 1ns/1ps
interface pdm_mic_capture_if #(
  parameter int SAMPLE_W = pdm_mic_pkg::DEF_SAMPLE_W,
  parameter int LVL_W    = pdm_mic_pkg::LVL_W
);
  logic [SAMPLE_W-1:0] sample_data;
  logic                sample_ch;
  logic                sample_valid;
  logic                sample_ready;
  logic [LVL_W-1:0]    fifo_level;
  logic                overflow;

  modport master (
    output sample_data, sample_ch, sample_valid, fifo_level, overflow,
    input  sample_ready
  );

  modport slave (
    input  sample_data, sample_ch, sample_valid, fifo_level, overflow,
    output sample_ready
  );
endinterface

// File: rtl/pdm_mic_capture_fifo.sv
// pdm_sample_fifo: first-word-fall-through FIFO for captured samples.
//   clk, reset (sync, active-low)
//   push/push_data : write request; accepted when not full or when popping
//   pop_req        : consumer ready; qualified internally with not-empty
//   head           : oldest entry, zero when empty
//   level/full/empty : occupancy status
`timescale 1ns/1ps
module pdm_sample_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 8,
  parameter int LVL_W = pdm_mic_pkg::lvl_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop_req,
  output logic [W-1:0]     head,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             pop_s;
  logic             wr_s;

  assign empty = (level_r == {LVL_W{1'b0}});
  assign full  = (level_r == LVL_W'(DEPTH));
  assign pop_s = pop_req && !empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign wr_s  = push && (!full || pop_s);
  assign level = level_r;
  assign head  = empty ? {W{1'b0}} : mem_r[rd_ptr_r];

  // Storage write; contents are only visible through the level-qualified head.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({wr_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end
endmodule

// File: rtl/pdm_mic_capture.sv
// pdm_mic_capture: PDM microphone front end.
//   clk, reset (sync, active-low), enable (0 stops mic_clk, clears datapath)
//   mic_data in / mic_clk out : microphone pins
//   sbus (master)             : sample stream {data, ch, valid/ready}, level, overflow
// Channel 0 is sampled at the end of the mic_clk high phase, channel 1 at
// the end of the low phase. Each channel counts ones over DECIM bits and
// emits 2*ones - DECIM as a signed sample into a FWFT FIFO.
`timescale 1ns/1ps
module pdm_mic_capture
  import pdm_mic_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int DECIM      = DEF_DECIM,
  parameter int SAMPLE_W   = DEF_SAMPLE_W,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              mic_data,
  output logic              mic_clk,
  pdm_mic_capture_if.master sbus
);
  localparam int DIV_W    = $clog2(CLK_DIV);
  localparam int CNT_BITS = cnt_w(DECIM);
  localparam int LVL_BITS = lvl_w(FIFO_DEPTH);

  logic [1:0]          sync_r;
  logic [DIV_W-1:0]    div_cnt_r;
  logic                mic_clk_r;
  logic                strobe_s;
  logic [NUM_CH-1:0]   ch_strobe_s;
  logic [NUM_CH-1:0]   push_v_s;
  logic [SAMPLE_W-1:0] ch_data_s [NUM_CH];
  logic                push_s;
  logic                push_ch_s;
  logic [SAMPLE_W-1:0] push_data_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic                pop_s;
  logic                overflow_r;
  logic [SAMPLE_W:0]   head_s;
  logic [LVL_BITS-1:0] level_s;

  // Two-flop synchronizer for the asynchronous microphone data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], mic_data};
    end
  end

  assign strobe_s = enable && (div_cnt_r == DIV_W'(CLK_DIV - 1));

  // mic_clk divider: toggles every CLK_DIV cycles, parked low while disabled.
  always_ff @(posedge clk) begin
    if (!reset || !enable) begin
      div_cnt_r <= {DIV_W{1'b0}};
      mic_clk_r <= 1'b0;
    end else if (strobe_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
      mic_clk_r <= ~mic_clk_r;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
      mic_clk_r <= mic_clk_r;
    end
  end

  assign mic_clk = mic_clk_r;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_BITS-1:0] ones_r;
    logic [CNT_BITS-1:0] bit_r;
    logic [CNT_BITS-1:0] total_s;

    // ch0 owns the end of the high phase, ch1 the end of the low phase.
    assign ch_strobe_s[c] = strobe_s && (mic_clk_r == ((c == 0) ? 1'b1 : 1'b0));
    assign total_s        = ones_r + CNT_BITS'(sync_r[1]);
    assign push_v_s[c]    = ch_strobe_s[c] && (bit_r == CNT_BITS'(DECIM - 1));
    // Modular SAMPLE_W arithmetic gives the correct signed 2*ones - DECIM.
    assign ch_data_s[c]   = SAMPLE_W'({total_s, 1'b0}) - SAMPLE_W'(DECIM);

    // Per-channel ones/bit counters; window restarts after each sample.
    always_ff @(posedge clk) begin
      if (!reset || !enable || push_v_s[c]) begin
        ones_r <= {CNT_BITS{1'b0}};
        bit_r  <= {CNT_BITS{1'b0}};
      end else if (ch_strobe_s[c]) begin
        ones_r <= total_s;
        bit_r  <= bit_r + CNT_BITS'(1);
      end else begin
        ones_r <= ones_r;
        bit_r  <= bit_r;
      end
    end
  end

  // Channel pushes are CLK_DIV cycles apart, so a simple select suffices.
  assign push_s      = |push_v_s;
  assign push_ch_s   = ((NUM_CH == 2) && push_v_s[NUM_CH-1]) ? CH_R : CH_L;
  assign push_data_s = (push_ch_s == CH_R) ? ch_data_s[NUM_CH-1] : ch_data_s[0];
  assign pop_s       = !fifo_empty_s && sbus.sample_ready;

  // Sticky drop flag, cleared whenever capture is stopped.
  always_ff @(posedge clk) begin
    if (!reset || !enable) begin
      overflow_r <= 1'b0;
    end else if (push_s && fifo_full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  pdm_sample_fifo #(
    .W     (SAMPLE_W + 1),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data ({push_ch_s, push_data_s}),
    .pop_req   (sbus.sample_ready),
    .head      (head_s),
    .level     (level_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign sbus.sample_data  = head_s[SAMPLE_W-1:0];
  assign sbus.sample_ch    = head_s[SAMPLE_W];
  assign sbus.sample_valid = !fifo_empty_s;
  assign sbus.fifo_level   = level_s;
  assign sbus.overflow     = overflow_r;
endmodule
